wash_ctrl_multi: RTL and testbench

Parametrised next-generation washing-machine controller with integrated seconds prescaler and phase timer. Runs a coin-started program: FILL, WASH, N x RINSE, optional second WASH/RINSE pass, then SPIN. Adds configurable rinse count, abort-to-drain, pause during spin, and observable state and remaining time. Sits at laundry-unit top level, driven by user-panel inputs.

---
 rtl/wash_ctrl_multi.sv | 128 ++++++++++++
 tb/tb_wash_ctrl_multi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_ctrl_multi.sv
// wash_ctrl_multi: coin-started washer sequencer (FILL, WASH, N x RINSE, optional second pass, SPIN) with seconds prescaler
module wash_ctrl_multi #(
    parameter int CNT_W     = 32,
    parameter int SEC_BASE  = 1000000,
    parameter int FILL_SEC  = 120,
    parameter int WASH_SEC  = 300,
    parameter int RINSE_SEC = 120,
    parameter int SPIN_SEC  = 60,
    parameter int MAX_RINSE = 3,
    parameter int RW        = $clog2(MAX_RINSE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       clk_freq,
    input  logic             coin_in,
    input  logic             double_wash,
    input  logic [RW-1:0]    rinse_cnt,
    input  logic             pause_in,
    input  logic             abort_in,
    output logic [2:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] sec_left,
    output logic             pass_idx,
    output logic             wash_done
);
    typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, WASH = 3'd2, RINSE = 3'd3, SPIN = 3'd4} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] sec_q, sec_d, pre_q, pre_d, lim;
    logic [1:0] freq_q, freq_d;
    logic [RW-1:0] rin_q, rin_d, rc_q, rc_d;
    logic dbl_q, dbl_d, pass_q, pass_d, done_q, done_d, tick, run;
    assign lim  = CNT_W'(SEC_BASE) << freq_q;
    assign tick = pre_q == lim - CNT_W'(1);
    assign run  = !(state_q == SPIN && pause_in);
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        pre_d   = pre_q;
        freq_d  = freq_q;
        dbl_d   = dbl_q;
        rin_d   = rin_q;
        rc_d    = rc_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (coin_in) begin
                state_d = FILL;
                sec_d   = CNT_W'(FILL_SEC);
                pre_d   = '0;
                freq_d  = clk_freq;
                dbl_d   = double_wash;
                rin_d   = rinse_cnt == '0 ? RW'(1) : rinse_cnt > RW'(MAX_RINSE) ? RW'(MAX_RINSE) : rinse_cnt;
                rc_d    = '0;
                pass_d  = 1'b0;
            end
        end else if (abort_in && state_q != SPIN) begin
            state_d = SPIN;
            sec_d   = CNT_W'(SPIN_SEC);
            pre_d   = '0;
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + CNT_W'(1);
            if (tick && sec_q != CNT_W'(1)) begin
                sec_d = sec_q - CNT_W'(1);
            end else if (tick) begin
                // rc_q counts rinses already started in the current pass
                case (state_q)
                    FILL: begin
                        state_d = WASH;
                        sec_d   = CNT_W'(WASH_SEC);
                    end
                    WASH: begin
                        state_d = RINSE;
                        sec_d   = CNT_W'(RINSE_SEC);
                        rc_d    = RW'(1);
                    end
                    RINSE: begin
                        if (rc_q < rin_q) begin
                            sec_d = CNT_W'(RINSE_SEC);
                            rc_d  = rc_q + RW'(1);
                        end else if (dbl_q && !pass_q) begin
                            state_d = WASH;
                            sec_d   = CNT_W'(WASH_SEC);
                            pass_d  = 1'b1;
                        end else begin
                            state_d = SPIN;
                            sec_d   = CNT_W'(SPIN_SEC);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        sec_d   = '0;
                        rc_d    = '0;
                        pass_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sec_q   <= '0;
            pre_q   <= '0;
            freq_q  <= '0;
            dbl_q   <= 1'b0;
            rin_q   <= '0;
            rc_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            pre_q   <= pre_d;
            freq_q  <= freq_d;
            dbl_q   <= dbl_d;
            rin_q   <= rin_d;
            rc_q    <= rc_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end
    assign state     = state_q;
    assign busy      = state_q != IDLE;
    assign sec_left  = sec_q;
    assign pass_idx  = pass_q;
    assign wash_done = done_q;
endmodule

// File: tb/tb_wash_ctrl_multi.sv
// tb_wash_ctrl_multi: randomized and directed checks of wash_ctrl_multi against a phase-list reference model
module tb_wash_ctrl_multi;
    localparam int SB = 2, FS = 1, WS = 2, RS = 1, SS = 2, MR = 3, CW = 32, RW = 2;
    logic clk = 1'b0, rst;
    logic [1:0] clk_freq;
    logic coin_in, double_wash, pause_in, abort_in;
    logic [RW-1:0] rinse_cnt;
    logic [2:0] state;
    logic busy, pass_idx, wash_done;
    logic [CW-1:0] sec_left;
    logic [37:0] got;
    int errs = 0, checks = 0;
    bit pv[512], av[512];
    int e_st[512], e_sec[512], e_pass[512], e_done[512];
    int e_len;

    wash_ctrl_multi #(.CNT_W(CW), .SEC_BASE(SB), .FILL_SEC(FS), .WASH_SEC(WS), .RINSE_SEC(RS),
                      .SPIN_SEC(SS), .MAX_RINSE(MR)) dut (
        .clk(clk), .rst(rst), .clk_freq(clk_freq), .coin_in(coin_in), .double_wash(double_wash),
        .rinse_cnt(rinse_cnt), .pause_in(pause_in), .abort_in(abort_in), .state(state), .busy(busy),
        .sec_left(sec_left), .pass_idx(pass_idx), .wash_done(wash_done));

    always #5 clk = ~clk;
    assign got = {state, busy, sec_left, pass_idx, wash_done};

    function automatic logic [37:0] exp_v(input int c);
        exp_v = {3'(e_st[c]), e_st[c] != 0, CW'(e_sec[c]), e_pass[c][0], e_done[c][0]};
    endfunction

    // Model: program as a list of (state, seconds, pass); walk it cycle by cycle with elapsed-cycle counts
    task automatic build_model(input int fq, input bit dw, input int rc);
        int cps, eff, p, e, ps;
        bit fin;
        int ph_st[$], ph_dur[$], ph_ps[$];
        cps = SB << fq;
        eff = rc == 0 ? 1 : (rc > MR ? MR : rc);
        ph_st = {1}; ph_dur = {FS}; ph_ps = {0};
        for (int k = 0; k < (dw ? 2 : 1); k++) begin
            ph_st.push_back(2); ph_dur.push_back(WS); ph_ps.push_back(k);
            for (int r = 0; r < eff; r++) begin
                ph_st.push_back(3); ph_dur.push_back(RS); ph_ps.push_back(k);
            end
        end
        ph_st.push_back(4); ph_dur.push_back(SS); ph_ps.push_back(-1);
        p = 0; e = 0; ps = 0; fin = 0; e_len = 0;
        for (int c = 1; c < 512; c++) begin
            if (fin) begin
                e_st[c] = 0; e_sec[c] = 0; e_pass[c] = 0; e_done[c] = int'(c == e_len);
                continue;
            end
            if (ph_ps[p] >= 0) ps = ph_ps[p];
            e_st[c] = ph_st[p]; e_sec[c] = ph_dur[p] - e / cps; e_pass[c] = ps; e_done[c] = 0;
            if (av[c] && ph_st[p] != 4) begin
                p = ph_st.size() - 1; e = 0;
            end else if (!(ph_st[p] == 4 && pv[c])) begin
                e++;
                if (e == ph_dur[p] * cps) begin
                    e = 0; p++;
                    if (p == ph_st.size()) begin fin = 1; e_len = c + 1; end
                end
            end
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < 512; c++) begin pv[c] = 0; av[c] = 0; end
    endtask

    task automatic go(input int fq, input bit dw, input int rc);
        build_model(fq, dw, rc);
        clk_freq = 2'(fq); double_wash = dw; rinse_cnt = RW'(rc); coin_in = 1'b1;
        @(posedge clk); #1;
        coin_in = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (got !== 38'd0) begin errs++; $display("FAIL reset_state got=%h want=0", got); end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (got !== 38'd0) begin errs++; $display("FAIL idle_after_reset got=%h want=0", got); end
    endtask

    task automatic test_single();
        int done_at = 0;
        clear_plan(); go(0, 0, 1);
        for (int c = 1; c <= e_len + 2; c++) begin
            checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL single c%0d got=%h want=%h", c, got, exp_v(c)); end
            if (c == 3) begin checks++; if (sec_left !== 2) begin errs++; $display("FAIL single_sec3 got=%0d want=2", sec_left); end end
            if (wash_done) done_at = c;
            @(posedge clk); #1;
        end
        checks++; if (done_at !== 13) begin errs++; $display("FAIL single_done got=%0d want=13", done_at); end
    endtask

    task automatic test_double();
        int done_at = 0;
        clear_plan(); go(0, 1, 2);
        for (int c = 1; c <= e_len + 2; c++) begin
            checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL double c%0d got=%h want=%h", c, got, exp_v(c)); end
            if (c == 12) begin checks++; if (pass_idx !== 1'b1 || state !== 3'd2) begin errs++; $display("FAIL double_pass2 got=%0d/%0d want=1/2", pass_idx, state); end end
            if (wash_done) done_at = c;
            @(posedge clk); #1;
        end
        checks++; if (done_at !== 23) begin errs++; $display("FAIL double_done got=%0d want=23", done_at); end
    endtask

    task automatic test_divisor();
        int done_at = 0;
        clear_plan(); go(1, 0, 1);
        for (int c = 1; c <= e_len + 2; c++) begin
            checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL divisor c%0d got=%h want=%h", c, got, exp_v(c)); end
            if (wash_done) done_at = c;
            clk_freq = 2'(c);
            @(posedge clk); #1;
        end
        checks++; if (done_at !== 25) begin errs++; $display("FAIL divisor_done got=%0d want=25", done_at); end
    endtask

    task automatic test_pause();
        int want[2] = '{18, 13};
        for (int s = 0; s < 2; s++) begin
            int done_at = 0;
            clear_plan();
            for (int c = 0; c < 5; c++) pv[s == 0 ? 10 + c : 3 + c] = 1;
            go(0, 0, 1);
            for (int c = 1; c <= e_len + 2; c++) begin
                checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL pause%0d c%0d got=%h want=%h", s, c, got, exp_v(c)); end
                if (wash_done) done_at = c;
                pause_in = pv[c];
                @(posedge clk); #1;
            end
            pause_in = 1'b0;
            checks++; if (done_at !== want[s]) begin errs++; $display("FAIL pause%0d_done got=%0d want=%0d", s, done_at, want[s]); end
        end
    endtask

    task automatic test_abort();
        int want[2] = '{9, 13};
        for (int s = 0; s < 2; s++) begin
            int done_at = 0;
            clear_plan(); av[s == 0 ? 4 : 10] = 1;
            go(0, 0, 1);
            for (int c = 1; c <= e_len + 2; c++) begin
                checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL abort%0d c%0d got=%h want=%h", s, c, got, exp_v(c)); end
                if (s == 0 && c == 5) begin checks++; if (state !== 3'd4 || sec_left !== 2) begin errs++; $display("FAIL abort_spin got=%0d/%0d want=4/2", state, sec_left); end end
                if (wash_done) done_at = c;
                abort_in = av[c];
                @(posedge clk); #1;
            end
            abort_in = 1'b0;
            checks++; if (done_at !== want[s]) begin errs++; $display("FAIL abort%0d_done got=%0d want=%0d", s, done_at, want[s]); end
        end
    endtask

    task automatic test_clamp();
        int rc[2] = '{0, 3};
        int want[2] = '{13, 17};
        for (int s = 0; s < 2; s++) begin
            int done_at = 0;
            clear_plan(); go(0, 0, rc[s]);
            rinse_cnt = '0;
            for (int c = 1; c <= e_len + 2; c++) begin
                checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL clamp%0d c%0d got=%h want=%h", s, c, got, exp_v(c)); end
                if (wash_done) done_at = c;
                @(posedge clk); #1;
            end
            checks++; if (done_at !== want[s]) begin errs++; $display("FAIL clamp%0d_done got=%0d want=%0d", s, done_at, want[s]); end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        clear_plan(); go(0, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL rstmid c%0d got=%h want=%h", c, got, exp_v(c)); end
            if (c < 4) begin @(posedge clk); #1; end
        end
        rst = 1'b1; #1;
        checks++; if (got !== 38'd0) begin errs++; $display("FAIL rst_async got=%h want=0", got); end
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (got !== 38'd0) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errs++; $display("FAIL rst_quiet got=%0d want=0", seen); end
        test_single();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int fq = $urandom_range(0, 2);
            bit dw = 1'($urandom_range(0, 1));
            int rc = $urandom_range(0, 3);
            clear_plan();
            for (int c = 1; c < 512; c++) begin
                pv[c] = $urandom_range(0, 3) == 0;
                av[c] = $urandom_range(0, 59) == 0;
            end
            go(fq, dw, rc);
            for (int c = 1; c <= e_len + 2; c++) begin
                checks++; if (got !== exp_v(c)) begin errs++; $display("FAIL rand%0d c%0d got=%h want=%h", it, c, got, exp_v(c)); end
                pause_in = pv[c]; abort_in = av[c] && c <= e_len - 1;
                clk_freq = 2'($urandom); rinse_cnt = RW'($urandom); double_wash = 1'($urandom);
                @(posedge clk); #1;
            end
            pause_in = 1'b0; abort_in = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; coin_in = 1'b0; double_wash = 1'b0; rinse_cnt = '0;
        pause_in = 1'b0; abort_in = 1'b0; clk_freq = '0;
        test_reset();
        test_single();
        test_double();
        test_divisor();
        test_pause();
        test_abort();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
